// File: rtl/pmod_gpio_pkg.sv
// pmod_gpio_pkg: shared limits, row packing helper and tristate reset level for the Pmod GPIO bridge
package pmod_gpio_pkg;
  localparam int MAX_ROWS = 4;
  localparam int MAX_ROW_WIDTH = 8;
  localparam logic TRI_RST = 1'b1;
  function automatic int row_slice_lo(int r, int row_width);
    return r * row_width;
  endfunction
endpackage

// File: rtl/pmod_gpio_input_cond.sv
// pmod_gpio_input_cond: per-pin two-flop synchroniser plus optional debounce feeding a stable level
// Ports: clk, rst (sync, active high), pin_i raw async level, stable_o conditioned level.
// Build option: PMOD_GPIO_DEBOUNCE_EN compiles in the DEBOUNCE_CYCLES hold counter.
module pmod_gpio_input_cond #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic stable_o
);
  logic sync1_q, sync2_q, stable_q, stable_d;
`ifdef PMOD_GPIO_DEBOUNCE_EN
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic diff, done;
  always_comb begin
    diff = sync2_q != stable_q;
    done = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    stable_d = diff && done ? sync2_q : stable_q;
    cnt_d = diff && !done ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  always_comb stable_d = sync2_q;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      stable_q <= stable_d;
    end
  assign stable_o = stable_q;
endmodule

// File: rtl/pmod_gpio_bridge.sv
// pmod_gpio_bridge: registered AXI GPIO tristate to Pmod row bridge with conditioned inputs and sticky change IRQ
// Ports: gpio_in_tri_t/o from AXI GPIO, gpio_in_tri_i conditioned levels back; pin_tri_t/o/i flattened rows
// (row r at [r*ROW_WIDTH +: ROW_WIDTH]); irq_mask, irq_clear (W1C), irq_status sticky flags, irq registered OR.
// Build option: PMOD_GPIO_DEBOUNCE_EN enables per-pin debounce of DEBOUNCE_CYCLES.
module pmod_gpio_bridge
  import pmod_gpio_pkg::*;
#(
  parameter int NUM_ROWS = 2,
  parameter int ROW_WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_ROWS*ROW_WIDTH-1:0] gpio_in_tri_t,
  input  logic [NUM_ROWS*ROW_WIDTH-1:0] gpio_in_tri_o,
  output logic [NUM_ROWS*ROW_WIDTH-1:0] gpio_in_tri_i,
  output logic [NUM_ROWS*ROW_WIDTH-1:0] pin_tri_t,
  output logic [NUM_ROWS*ROW_WIDTH-1:0] pin_tri_o,
  input  logic [NUM_ROWS*ROW_WIDTH-1:0] pin_tri_i,
  input  logic [NUM_ROWS*ROW_WIDTH-1:0] irq_mask,
  input  logic [NUM_ROWS*ROW_WIDTH-1:0] irq_clear,
  output logic [NUM_ROWS*ROW_WIDTH-1:0] irq_status,
  output logic                          irq
);
  localparam int W = NUM_ROWS * ROW_WIDTH;
  logic [W-1:0] tri_t_q, tri_o_q, stable, stable_dly_q, status_q, status_d, evt;
  logic irq_q;
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar c = 0; c < ROW_WIDTH; c++) begin : g_pin
      pmod_gpio_input_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
        .clk      (clk),
        .rst      (rst),
        .pin_i    (pin_tri_i[row_slice_lo(r, ROW_WIDTH) + c]),
        .stable_o (stable[row_slice_lo(r, ROW_WIDTH) + c])
      );
    end
  end
  // Only unmasked input-mode pins raise events; set beats a same-cycle clear.
  always_comb begin
    evt = (stable ^ stable_dly_q) & tri_t_q & irq_mask;
    status_d = (status_q & ~irq_clear) | evt;
  end
  always_ff @(posedge clk)
    if (rst) begin
      tri_t_q <= {W{TRI_RST}};
      tri_o_q <= '0;
      stable_dly_q <= '0;
      status_q <= '0;
      irq_q <= 1'b0;
    end else begin
      tri_t_q <= gpio_in_tri_t;
      tri_o_q <= gpio_in_tri_o;
      stable_dly_q <= stable;
      status_q <= status_d;
      irq_q <= |status_q;
    end
  assign pin_tri_t = tri_t_q;
  assign pin_tri_o = tri_o_q;
  assign gpio_in_tri_i = stable;
  assign irq_status = status_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_pmod_gpio_bridge.sv
// tb_pmod_gpio_bridge: randomized and directed self-check of pmod_gpio_bridge against a window-based model
module tb_pmod_gpio_bridge;
  localparam int W = 8;
  localparam int W2 = 24;
`ifdef PMOD_GPIO_DEBOUNCE_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] gpio_t, gpio_o, gpio_i, pin_t, pin_o, pin_i, mask, clr, stat;
  logic irq;
  logic [W2-1:0] t2, o2, gi2, pt2, po2, pi2, mask2, clr2, stat2;
  logic irq2;
  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  pmod_gpio_bridge #(.NUM_ROWS(2), .ROW_WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .gpio_in_tri_t(gpio_t), .gpio_in_tri_o(gpio_o), .gpio_in_tri_i(gpio_i),
    .pin_tri_t(pin_t), .pin_tri_o(pin_o), .pin_tri_i(pin_i), .irq_mask(mask), .irq_clear(clr),
    .irq_status(stat), .irq(irq));

  pmod_gpio_bridge #(.NUM_ROWS(3), .ROW_WIDTH(8), .DEBOUNCE_CYCLES(4)) dut2 (
    .clk(clk), .rst(rst), .gpio_in_tri_t(t2), .gpio_in_tri_o(o2), .gpio_in_tri_i(gi2),
    .pin_tri_t(pt2), .pin_tri_o(po2), .pin_tri_i(pi2), .irq_mask(mask2), .irq_clear(clr2),
    .irq_status(stat2), .irq(irq2));

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Model: a new input level is accepted once the synchronised level has disagreed
  // with the accepted level on each of the last D edges.
  logic [W-1:0] m_t, m_o, m_s1, m_s2, m_st, m_std, m_stat, evt;
  logic m_irq, allx;
  logic [W-1:0] win[$];
  always @(posedge clk) begin
    if (rst) begin
      m_t = '1; m_o = '0; m_s1 = '0; m_s2 = '0; m_st = '0; m_std = '0; m_stat = '0; m_irq = 1'b0;
      win.delete();
    end else begin
      evt = (m_st ^ m_std) & m_t & mask;
      m_irq = |m_stat;
      m_stat = (m_stat & ~clr) | evt;
      m_std = m_st;
      win.push_back(m_s2);
      if (win.size() > D) void'(win.pop_front());
      if (win.size() == D)
        for (int b = 0; b < W; b++) begin
          allx = 1'b1;
          for (int j = 0; j < D; j++) if (win[j][b] == m_st[b]) allx = 1'b0;
          if (allx) m_st[b] = ~m_st[b];
        end
      m_s2 = m_s1;
      m_s1 = pin_i;
      m_t = gpio_t;
      m_o = gpio_o;
    end
  end

  always @(negedge clk)
    if (chk_en) begin
      check("pin_tri_t", pin_t, m_t);
      check("pin_tri_o", pin_o, m_o);
      check("gpio_in_tri_i", gpio_i, m_st);
      check("irq_status", stat, m_stat);
      check("irq", irq, m_irq);
    end

  initial begin
    rst = 1'b1; gpio_t = 8'h00; gpio_o = 8'hA5; pin_i = '0; mask = '0; clr = '0;
    t2 = '1; o2 = '0; pi2 = '0; mask2 = '1; clr2 = '0;
    step();
    chk_en = 1'b1;
    step();
    check("rst_pin_tri_t", pin_t, 8'hFF);
    check("rst_pin_tri_o", pin_o, 8'h00);
    check("rst_irq", irq, 1'b0);
    check("rst_gpio_in_tri_i", gpio_i, 8'h00);
    rst = 1'b0;
    step();
    check("out_tri_t", pin_t, 8'h00);
    check("out_tri_o", pin_o, 8'hA5);
    check("row1", pin_o[7:4], 4'hA);
    check("row0", pin_o[3:0], 4'h5);
    // wide instance: one pin in the top row
    repeat (3) step();
    pi2[23] = 1'b1;
    repeat (D + 3) step();
    check("w24_status", stat2, 24'h800000);
    check("w24_in", gi2, 24'h800000);
    // rising input on unmasked pin 0
    gpio_t = 8'hFF; mask = 8'h01;
    repeat (3) step();
    pin_i[0] = 1'b1;
    repeat (D + 1) step();
    check("pin0_early", gpio_i[0], 1'b0);
    step();
    check("pin0_in", gpio_i[0], 1'b1);
    check("pin0_stat_early", stat, 8'h00);
    step();
    check("pin0_stat", stat, 8'h01);
    check("pin0_irq_early", irq, 1'b0);
    step();
    check("pin0_irq", irq, 1'b1);
    // masked pin 1
    pin_i[1] = 1'b1;
    repeat (D + 4) step();
    check("masked_in", gpio_i, 8'h03);
    check("masked_stat", stat, 8'h01);
    // clear colliding with a new falling event on pin 0
    pin_i[0] = 1'b0;
    repeat (D + 2) step();
    clr = 8'h01;
    step();
    clr = 8'h00;
    check("set_wins", stat, 8'h01);
    clr = 8'h01;
    step();
    clr = 8'h00;
    check("clear_stat", stat, 8'h00);
    check("clear_irq_hold", irq, 1'b1);
    step();
    check("clear_irq_drop", irq, 1'b0);
`ifdef PMOD_GPIO_DEBOUNCE_EN
    mask = 8'hFF;
    pin_i[2] = 1'b1;
    repeat (3) step();
    pin_i[2] = 1'b0;
    repeat (10) step();
    check("glitch_in", gpio_i[2], 1'b0);
    check("glitch_stat", stat, 8'h00);
    pin_i[2] = 1'b1;
    repeat (D + 1) step();
    check("hold_early", gpio_i[2], 1'b0);
    step();
    check("hold_in", gpio_i[2], 1'b1);
    repeat (3) step();
    clr = 8'hFF;
    step();
    clr = 8'h00;
`endif
    // output-mode pin 3
    mask = 8'hFF; gpio_t = 8'hF7;
    repeat (2) step();
    pin_i[3] = 1'b1;
    repeat (D + 2) step();
    check("outpin_in_hi", gpio_i[3], 1'b1);
    repeat (3) step();
    check("outpin_stat_hi", stat[3], 1'b0);
    pin_i[3] = 1'b0;
    repeat (D + 4) step();
    check("outpin_in_lo", gpio_i[3], 1'b0);
    check("outpin_stat_lo", stat[3], 1'b0);
    // randomized traffic with occasional resets
    repeat (2000) begin
      rst = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 3) == 0) pin_i = pin_i ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 49) == 0) gpio_t = 8'($urandom);
      if ($urandom_range(0, 39) == 0) mask = 8'($urandom);
      gpio_o = 8'($urandom);
      clr = $urandom_range(0, 9) == 0 ? 8'($urandom) : 8'h00;
      step();
    end
    rst = 1'b0; clr = '0;
    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pmod_gpio_bridge.md
# pmod_gpio_bridge

Parametrised GPIO-to-Pmod bridge between an AXI GPIO tristate interface and NUM_ROWS Pmod bridge rows of ROW_WIDTH pins each. It registers the output and tristate paths and synchronises the input path, with optional per-pin debounce. It also raises a maskable, sticky change-of-state interrupt for pins configured as inputs. It supersedes the fixed 8-pin, two-row combinational remap.

## Interface
Parameters:
- NUM_ROWS, 2: number of Pmod rows (1..4).
- ROW_WIDTH, 4: pins per row (1..8). W = NUM_ROWS*ROW_WIDTH throughout.
- DEBOUNCE_CYCLES, 1000: cycles an input must hold a new level before it is accepted (>=1). Used only with debounce compiled in.

Ports:
- clk  in  1  system clock; all logic rises on it.
- rst  in  1  synchronous, active-high reset.
- gpio_in_tri_t  in  W  tristate enable from AXI GPIO; 1 = pin is an input.
- gpio_in_tri_o  in  W  output data from AXI GPIO.
- gpio_in_tri_i  out  W  conditioned pin levels to AXI GPIO.
- pin_tri_t  out  W  flattened row tristate enables; row r occupies bits [r*ROW_WIDTH +: ROW_WIDTH].
- pin_tri_o  out  W  flattened row output data, same packing.
- pin_tri_i  in  W  raw, asynchronous row input levels, same packing.
- irq_mask  in  W  1 = change on this pin may set status.
- irq_clear  in  W  write-one-to-clear pulse per status bit.
- irq_status  out  W  sticky change-of-state flags.
- irq  out  1  registered OR of irq_status.

## Operation
- Output path: pin_tri_t and pin_tri_o are gpio_in_tri_t and gpio_in_tri_o registered once.
- Input conditioning, per pin: a two-flop synchroniser (sync1, sync2) feeds a stable register. gpio_in_tri_i = stable.
- Without debounce: stable <= sync2 every cycle.
- With debounce, per-pin counter of width $clog2(DEBOUNCE_CYCLES):
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0.
  - otherwise: counter increments.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is discarded.
- Change detect: a pin has an event when stable differs from stable_d (stable delayed one cycle), pin_tri_t is 1, and irq_mask is 1. Both rising and falling changes count.
- Status update: irq_status <= (irq_status & ~irq_clear) | event. If set and clear hit the same bit in the same cycle, set wins.
- Output-mode pins (pin_tri_t = 0) never set status. Their bits are still readable on gpio_in_tri_i.
- Changing irq_mask never clears existing status.

## Timing
- Reset values: pin_tri_t = all 1 (all pins inputs, safe). pin_tri_o = 0. gpio_in_tri_i = 0. irq_status = 0. irq = 0. All sync/stable/counter registers = 0.
- Output latency: gpio_in_tri_* to pin_tri_* is 1 cycle.
- Input latency, pin_tri_i changing before edge k:
  - sync2 updates at edge k+1.
  - stable (gpio_in_tri_i) updates at edge k+1+D, where D = DEBOUNCE_CYCLES with debounce and D = 1 without.
  - irq_status sets at edge k+2+D.
  - irq asserts at edge k+3+D.
- irq deasserts one cycle after the edge that clears the last status bit.
- Reset asserted mid-debounce abandons the count. After reset the first accepted level is measured against stable = 0.
- A pin high coming out of reset produces one event once accepted, provided it is an unmasked input.

## Configuration
- PMOD_GPIO_DEBOUNCE_EN defined: the per-pin debounce counter is compiled in and DEBOUNCE_CYCLES is honoured.
- PMOD_GPIO_DEBOUNCE_EN undefined: no counters are built, stable follows sync2 with D = 1, and DEBOUNCE_CYCLES is ignored.

## Structure
- Shared package pmod_gpio_pkg holds:
  - the maximum NUM_ROWS and ROW_WIDTH constants;
  - a function row_slice_lo(r, ROW_WIDTH) giving the low bit index of row r;
  - the reset constant for tristate (all inputs).
- Sub-module pmod_gpio_input_cond is one per pin, generated W times. It holds sync1, sync2, the optional debounce counter and stable, and outputs stable.
- Output registers, edge detect, status and irq stay in the top.

## Test plan
- Reset with gpio_in_tri_t = 0x00 and gpio_in_tri_o = 0xA5 (defaults, no debounce) -> during reset pin_tri_t = 0xFF, pin_tri_o = 0x00, irq = 0. One cycle after release pin_tri_t = 0x00 and pin_tri_o = 0xA5, with row 1 = 0xA and row 0 = 0x5.
- gpio_in_tri_t = 0xFF, irq_mask = 0x01, pin_tri_i[0] rising before edge k (no debounce) -> gpio_in_tri_i[0] = 1 after edge k+2, irq_status = 0x01 at k+3, irq = 1 at k+4. The same toggle on masked pin 1 leaves status at 0x01.
- Debounce enabled, DEBOUNCE_CYCLES = 4: a 3-cycle high pulse on pin 2 -> gpio_in_tri_i and irq_status unchanged. A 4-cycle hold -> accepted at edge k+5.
- irq_clear = 0x01 in the same cycle a new event sets bit 0 -> bit 0 stays 1. irq_clear alone -> bit 0 = 0, and irq drops 1 cycle later.
- Pin 3 driven as output (tri_t[3] = 0) while pin_tri_i[3] toggles -> gpio_in_tri_i[3] tracks the pin, irq_status[3] stays 0.
- NUM_ROWS = 3, ROW_WIDTH = 8, irq_mask = all 1: toggle pin_tri_i[23] -> irq_status = 0x800000, and the other rows are unaffected.
